// File: rtl/mux_nx1_stream_if.sv
// mux_nx1_stream_if: bundles the N producer streams and the single
// consumer stream of the N:1 stream multiplexer.
interface mux_nx1_stream_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   out_chan;

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: N-input valid/ready stream mux with a registered
// output stage; external select (MODE=0) or round-robin (MODE=1).
module mux_nx1_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N),
    parameter int MODE  = 0
) (
    input logic             clk,
    input logic             rst,
    mux_nx1_stream_if.slave bus
);
    localparam int PAD = 1 << SEL_W;

    logic [PAD-1:0]   valid_pad;
    logic             load_en;
    logic             gnt_vld;
    logic             xfer;
    logic             found;
    logic [SEL_W-1:0] gnt;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] ptr;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] chan_q;
    logic             valid_q;
    int               c;

    // Padding lets any sel value index safely, even when N is not 2^k.
    assign valid_pad = PAD'(bus.in_valid);
    assign load_en   = !valid_q || bus.out_ready;
    assign xfer      = !rst && load_en && gnt_vld;

    // Choose the granted channel: external select or rotating scan.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        found   = 1'b0;
        idx     = '0;
        c       = 0;
        if (MODE == 0) begin
            gnt     = bus.sel;
            gnt_vld = (int'(bus.sel) < N) && valid_pad[bus.sel];
        end else begin
            for (int k = 0; k < N; k++) begin
                c = int'(ptr) + k;
                if (c >= N) begin
                    c = c - N;
                end
                idx = SEL_W'(c);
                if (!found && valid_pad[idx]) begin
                    gnt   = idx;
                    found = 1'b1;
                end
            end
            gnt_vld = |bus.in_valid;
        end
    end

    // Ready goes only to the granted channel, and only if it can load.
    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[gnt] = 1'b1;
        end
    end

    // Output register: load on transfer, drop valid on a bare pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= bus.in_data[int'(gnt)*WIDTH +: WIDTH];
            chan_q  <= gnt;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner only on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer && MODE == 1) begin
            ptr <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_chan  = chan_q;
endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb_mux_nx1_stream: three configurations (select N=4, round-robin N=4,
// select N=3) checked each cycle against a behavioural model.
module tb_mux_nx1_stream;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int nch  [3] = '{4, 4, 3};
    int mode [3] = '{0, 1, 0};

    bit [7:0] md [3][4];
    bit       mv [3][4];
    int       ms [3];
    bit       mr [3];

    bit       ev [3];
    bit [7:0] ed [3];
    int       ec [3];
    int       ptr[3];
    int       last_acc[3];

    int passed = 0;
    int total  = 0;
    bit cmp_on = 1'b0;

    mux_nx1_stream_if #(.WIDTH(8), .N(4)) ifa ();
    mux_nx1_stream_if #(.WIDTH(8), .N(4)) ifb ();
    mux_nx1_stream_if #(.WIDTH(8), .N(3)) ifc ();

    mux_nx1_stream #(.WIDTH(8), .N(4), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    mux_nx1_stream #(.WIDTH(8), .N(4), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );
    mux_nx1_stream #(.WIDTH(8), .N(3), .MODE(0)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc)
    );

    always_comb begin
        ifa.in_data   = {md[0][3], md[0][2], md[0][1], md[0][0]};
        ifa.in_valid  = {mv[0][3], mv[0][2], mv[0][1], mv[0][0]};
        ifa.sel       = 2'(ms[0]);
        ifa.out_ready = mr[0];
        ifb.in_data   = {md[1][3], md[1][2], md[1][1], md[1][0]};
        ifb.in_valid  = {mv[1][3], mv[1][2], mv[1][1], mv[1][0]};
        ifb.sel       = 2'(ms[1]);
        ifb.out_ready = mr[1];
        ifc.in_data   = {md[2][2], md[2][1], md[2][0]};
        ifc.in_valid  = {mv[2][2], mv[2][1], mv[2][0]};
        ifc.sel       = 2'(ms[2]);
        ifc.out_ready = mr[2];
    end

    // Granted channel index for config d, or -1 when nothing is granted.
    function automatic int mgrant(input int d);
        if (mode[d] == 0) begin
            if (ms[d] < nch[d] && mv[d][ms[d]]) return ms[d];
            return -1;
        end
        for (int k = 0; k < nch[d]; k++) begin
            int ch;
            ch = (ptr[d] + k) % nch[d];
            if (mv[d][ch]) return ch;
        end
        return -1;
    endfunction

    function automatic bit mload(input int d);
        return !ev[d] || mr[d];
    endfunction

    function automatic int exp_ready(input int d);
        int g;
        g = mgrant(d);
        if (mload(d) && g >= 0) return 1 << g;
        return 0;
    endfunction

    // Behavioural model of the output stage and pointer.
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                ev[d] = 1'b0;
                ed[d] = 8'h00;
                ec[d] = 0;
                ptr[d] = 0;
                last_acc[d] = -1;
            end else begin
                int g;
                bit le;
                g  = mgrant(d);
                le = mload(d);
                last_acc[d] = -1;
                if (le && g >= 0) begin
                    ev[d] = 1'b1;
                    ed[d] = md[d][g];
                    ec[d] = g;
                    last_acc[d] = g;
                    if (mode[d] == 1) ptr[d] = (g + 1) % nch[d];
                end else if (ev[d] && mr[d]) begin
                    ev[d] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic cmp(input int d, input int rdy, input int v,
                       input int dat, input int ch);
        chk($sformatf("d%0d in_ready", d), rdy, exp_ready(d));
        chk($sformatf("d%0d out_valid", d), v, int'(ev[d]));
        chk($sformatf("d%0d out_data", d), dat, int'(ed[d]));
        chk($sformatf("d%0d out_chan", d), ch, ec[d]);
    endtask

    // Every cycle, every configuration against the model.
    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            cmp(0, int'(ifa.in_ready), int'(ifa.out_valid),
                int'(ifa.out_data), int'(ifa.out_chan));
            cmp(1, int'(ifb.in_ready), int'(ifb.out_valid),
                int'(ifb.out_data), int'(ifb.out_chan));
            cmp(2, int'(ifc.in_ready), int'(ifc.out_valid),
                int'(ifc.out_data), int'(ifc.out_chan));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                md[d][i] = 8'h00;
                mv[d][i] = 1'b0;
            end
            ms[d] = 0;
            mr[d] = 1'b1;
        end
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) mv[0][i] = 1'b1;
        #2;
        chk("rst in_ready", int'(ifa.in_ready), 0);
        chk("rst out_valid", int'(ifa.out_valid), 0);
        chk("rst out_data", int'(ifa.out_data), 0);
        chk("rst out_chan", int'(ifa.out_chan), 0);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) mv[0][i] = 1'b0;
        #2 rst = 1'b0;
        cmp_on = 1'b1;

        // Out-of-range select on the 3-channel mux
        ms[2] = 3;
        for (int i = 0; i < 3; i++) mv[2][i] = 1'b1;
        @(negedge clk);
        chk("oor in_ready", int'(ifc.in_ready), 0);
        step();
        @(negedge clk);
        chk("oor out_valid", int'(ifc.out_valid), 0);

        // Basic select: ch2 carries A5
        step();
        ms[0] = 2;
        mv[0][2] = 1'b1;
        md[0][2] = 8'hA5;
        @(negedge clk);
        chk("sel2 in_ready", int'(ifa.in_ready), 4'b0100);
        step();
        mv[0][2] = 1'b0;
        @(negedge clk);
        chk("sel2 out_valid", int'(ifa.out_valid), 1);
        chk("sel2 out_data", int'(ifa.out_data), 8'hA5);
        chk("sel2 out_chan", int'(ifa.out_chan), 2);

        // Stall with a select change underneath
        step();
        ms[0] = 1;
        mv[0][1] = 1'b1;
        md[0][1] = 8'h3C;
        step();
        mv[0][1] = 1'b0;
        mr[0] = 1'b0;
        ms[0] = 3;
        mv[0][3] = 1'b1;
        md[0][3] = 8'h77;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall out_data", int'(ifa.out_data), 8'h3C);
            chk("stall out_chan", int'(ifa.out_chan), 1);
            chk("stall in_ready", int'(ifa.in_ready), 0);
            if (k < 2) step();
        end
        step();
        mr[0] = 1'b1;
        @(negedge clk);
        chk("release in_ready", int'(ifa.in_ready), 4'b1000);
        step();
        mv[0][3] = 1'b0;
        @(negedge clk);
        chk("release out_valid", int'(ifa.out_valid), 1);
        chk("release out_data", int'(ifa.out_data), 8'h77);
        chk("release out_chan", int'(ifa.out_chan), 3);

        // Round-robin fairness, all four requesting
        step();
        for (int i = 0; i < 4; i++) begin
            mv[1][i] = 1'b1;
            md[1][i] = 8'(8'h10 + i);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 7) for (int i = 0; i < 4; i++) mv[1][i] = 1'b0;
            @(negedge clk);
            chk("rr out_chan", int'(ifb.out_chan), k % 4);
            chk("rr out_data", int'(ifb.out_data), 8'h10 + k % 4);
        end

        // Sparse requests: move pointer to 2 with a ch1 beat first
        step();
        mv[1][1] = 1'b1;
        md[1][1] = 8'h11;
        step();
        mv[1][1] = 1'b0;
        step();
        mv[1][1] = 1'b1;
        mv[1][3] = 1'b1;
        md[1][3] = 8'h33;
        step();
        mr[1] = 1'b0;
        @(negedge clk);
        chk("sparse first", int'(ifb.out_chan), 3);
        chk("sparse first data", int'(ifb.out_data), 8'h33);
        step();
        @(negedge clk);
        chk("sparse stall", int'(ifb.out_chan), 3);
        step();
        mr[1] = 1'b1;
        @(negedge clk);
        chk("sparse held", int'(ifb.out_chan), 3);
        chk("sparse ready", int'(ifb.in_ready), 4'b0010);
        step();
        @(negedge clk);
        chk("sparse second", int'(ifb.out_chan), 1);
        step();
        mv[1][1] = 1'b0;
        mv[1][3] = 1'b0;
        @(negedge clk);
        chk("sparse third", int'(ifb.out_chan), 3);

        // Asynchronous reset while holding a stalled FF beat
        step();
        ms[0] = 0;
        mv[0][0] = 1'b1;
        md[0][0] = 8'hFF;
        step();
        mv[0][0] = 1'b0;
        mr[0] = 1'b0;
        @(negedge clk);
        chk("hold FF", int'(ifa.out_data), 8'hFF);
        #2 rst = 1'b1;
        #1;
        chk("async out_valid", int'(ifa.out_valid), 0);
        chk("async out_data", int'(ifa.out_data), 0);
        chk("async out_chan", int'(ifa.out_chan), 0);
        mr[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mv[1][i] = 1'b1;
            md[1][i] = 8'(8'h50 + i);
        end
        @(negedge clk);
        chk("async in_ready", int'(ifb.in_ready), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) mv[1][i] = 1'b0;
        @(negedge clk);
        chk("post-rst chan", int'(ifb.out_chan), 0);
        chk("post-rst data", int'(ifb.out_data), 8'h50);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            step();
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < nch[d]; i++) begin
                    if (!(mv[d][i] && last_acc[d] != i)) begin
                        mv[d][i] = ($urandom_range(0, 3) != 0);
                        md[d][i] = 8'($urandom);
                    end
                end
                ms[d] = $urandom_range(0, 3);
                mr[d] = ($urandom_range(0, 3) != 0);
            end
        end
        step();
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
